draw_image_rect: RTL

Pixel-fetch stage that reads a 48 x 64 image from the synchronous image ROM and overlays it on the VGA pixel stream at position (xpos, ypos). It sits in the VGA pipeline between the background/timing stage and the output register stage. It generates the ROM address from the incoming h/v counters, absorbs the ROM's one-cycle read latency, and re-aligns all timing signals with the fetched pixel.

---
 rtl/draw_pkg.sv | 37 +++
 rtl/signal_delay.sv | 37 +++
 rtl/draw_image_rect.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared widths, defaults and types for the image overlay stage
//
// Purpose: constants and types shared by draw_image_rect and its helpers.
// Ports: none (package).

package draw_pkg;

  localparam int IMG_W_DEF = 48;   // default image width in pixels
  localparam int IMG_H_DEF = 64;   // default image height in pixels
  localparam int ADDR_W    = 12;   // ROM address width {y[5:0], x[5:0]}
  localparam int IMG_AW    = 6;    // per-axis address bits inside the ROM
  localparam int COORD_W   = 11;   // screen coordinate width
  localparam int REL_W     = COORD_W + 1;  // one extra bit exposes negative offsets
  localparam int RGB_W     = 12;   // {r,g,b}, 4 bits each

  // Everything that must stay aligned with the pixel as it moves down the pipe.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

  // True when a signed offset lies in [0, span). The sign bit rejects pixels
  // left of / above the image, so a large position can never wrap into a hit.
  function automatic logic in_span(input logic [REL_W-1:0] rel, input int span);
    logic [REL_W-1:0] lim;
    lim = span[REL_W-1:0];
    return !rel[REL_W-1] && (rel < lim);
  endfunction

endpackage

// File: rtl/signal_delay.sv
// rtl/signal_delay.sv - parameterised width/depth shift register with async reset
//
// Purpose: delays a bus by DEPTH clock cycles; every stage clears on reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears all stages to 0
//   d_i  - WIDTH-bit input
//   d_o  - WIDTH-bit output, d_i delayed by DEPTH cycles

module signal_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign d_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_image_rect.sv
// rtl/draw_image_rect.sv - overlays an image fetched from a synchronous ROM onto the VGA stream
//
// Purpose: computes the ROM address of the image pixel under the beam, hides
// the ROM's one-cycle read latency, and composites the fetched pixel over the
// background with all timing signals re-aligned (3-cycle latency, no stalls).
// Optional feature macro: DRAW_IMAGE_POS_LATCH_EN - when defined, xpos/ypos
// are captured once per frame (at hcount_in == 0 && vcount_in == 0) so the
// image cannot tear mid-frame; otherwise they are used every cycle.
// Ports:
//   clk, rst                 - pixel clock; asynchronous active-high reset
//   hcount_in .. vblnk_in    - incoming VGA timing
//   rgb_in                   - background pixel {r,g,b}
//   xpos, ypos               - image top-left corner in screen coordinates
//   pixel_addr               - ROM address {y[5:0], x[5:0]}, 0 outside the image
//   rom_rgb                  - ROM data, one cycle after pixel_addr
//   hcount_out .. vblnk_out  - timing delayed by 3 cycles
//   rgb_out                  - composited pixel

module draw_image_rect
  import draw_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic [ADDR_W-1:0]  pixel_addr,
  input  logic [RGB_W-1:0]   rom_rgb,
  output logic [COORD_W-1:0] hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [COORD_W-1:0] vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

  // ---------------------------------------------------------------------------
  // Effective image position
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] xpos_eff;
  logic [COORD_W-1:0] ypos_eff;

`ifdef DRAW_IMAGE_POS_LATCH_EN
  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;

  // Shadow copy taken on the first pixel of the frame; the capture cycle
  // itself still uses the previous frame's position.
  always_comb begin
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    if ((hcount_in == '0) && (vcount_in == '0)) begin
      xpos_d = xpos;
      ypos_d = ypos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  assign xpos_eff = xpos_q;
  assign ypos_eff = ypos_q;
`else
  assign xpos_eff = xpos;
  assign ypos_eff = ypos;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: hit test and ROM address
  // ---------------------------------------------------------------------------
  logic [REL_W-1:0]  rel_x;
  logic [REL_W-1:0]  rel_y;
  logic              in_rect_d;
  logic              in_rect_q;
  logic [ADDR_W-1:0] pixel_addr_d;
  logic [ADDR_W-1:0] pixel_addr_q;

  always_comb begin
    rel_x        = {1'b0, hcount_in} - {1'b0, xpos_eff};
    rel_y        = {1'b0, vcount_in} - {1'b0, ypos_eff};
    in_rect_d    = in_span(rel_x, IMG_W) && in_span(rel_y, IMG_H) &&
                   !hblnk_in && !vblnk_in;
    pixel_addr_d = '0;
    if (in_rect_d) begin
      pixel_addr_d = {rel_y[IMG_AW-1:0], rel_x[IMG_AW-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_rect_q    <= 1'b0;
      pixel_addr_q <= '0;
    end else begin
      in_rect_q    <= in_rect_d;
      pixel_addr_q <= pixel_addr_d;
    end
  end

  assign pixel_addr = pixel_addr_q;

  // ---------------------------------------------------------------------------
  // Stage 2: ROM read in flight; align hit flag and the VGA bundle with it
  // ---------------------------------------------------------------------------
  vga_bus_t bus_in;
  vga_bus_t bus_d2;
  logic     in_rect_d2;

  assign bus_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                    rgb: rgb_in};

  signal_delay #(
    .WIDTH (VGA_BUS_W),
    .DEPTH (2)
  ) u_bus_delay (
    .clk (clk),
    .rst (rst),
    .d_i (bus_in),
    .d_o (bus_d2)
  );

  signal_delay #(
    .WIDTH (1),
    .DEPTH (1)
  ) u_rect_delay (
    .clk (clk),
    .rst (rst),
    .d_i (in_rect_q),
    .d_o (in_rect_d2)
  );

  // ---------------------------------------------------------------------------
  // Stage 3: composite and register outputs
  // ---------------------------------------------------------------------------
  vga_bus_t out_d;
  vga_bus_t out_q;

  always_comb begin
    out_d = bus_d2;
    if (in_rect_d2) begin
      out_d.rgb = rom_rgb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign hcount_out = out_q.hcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vcount_out = out_q.vcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule
